psum_collector: RTL and testbench

PSUM_COLLECTOR -- requirements
Module: psum_collector

---
 rtl/bnn_pkg.sv | 8 +
 rtl/psum_bit_packer.sv | 59 +++++
 rtl/psum_collector.sv | 68 ++++++
 tb/tb_psum_collector.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// bnn_pkg: shared widths and collector state encoding for the BNN psum path
package bnn_pkg;
  localparam int PSUM_W = 7;
  localparam int ACT_W = 9;
  localparam int ACC_W = 11;
  localparam int PASS_W = 4;
  typedef enum logic {ACC, EMIT} state_e;
endpackage

// File: rtl/psum_bit_packer.sv
// psum_bit_packer: packs threshold bits into a word and holds it until the downstream handshake
module psum_bit_packer
  import bnn_pkg::*;
#(
  parameter int N = ACT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         bit_valid_i,
  input  logic         bit_i,
  input  logic         flush_i,
  input  logic         word_ready_i,
  output logic         ready_o,
  output logic         has_bits_o,
  output logic         word_valid_o,
  output logic [N-1:0] word_o
);
  localparam int CW = $clog2(N + 1);
  state_e state_q, state_d;
  logic [N-1:0] data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic full;
  assign full = bit_valid_i && cnt_q == CW'(N - 1);
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      state_q <= ACC;
      data_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      cnt_q <= cnt_d;
    end
  end
  // flush_i is only raised by the top when there is something to emit
  always_comb begin
    state_d = state_q;
    data_d = data_q;
    cnt_d = cnt_q;
    if (state_q == ACC) begin
      if (bit_valid_i) begin
        data_d[cnt_q] = bit_i;
        cnt_d = cnt_q + CW'(1);
      end
      state_d = (full || flush_i) ? EMIT : ACC;
    end else if (word_ready_i) begin
      state_d = ACC;
      data_d = '0;
      cnt_d = '0;
    end
  end
  always_comb begin
    ready_o = state_q == ACC;
    word_valid_o = state_q == EMIT;
    word_o = data_q;
    has_bits_o = cnt_q != '0;
  end
endmodule

// File: rtl/psum_collector.sv
// psum_collector: accumulates column psums per neuron, thresholds to a binary
// activation and hands packed words downstream through psum_bit_packer
module psum_collector #(
  parameter int PSUM_W = bnn_pkg::PSUM_W,
  parameter int ACT_W = bnn_pkg::ACT_W,
  parameter int ACC_W = bnn_pkg::ACC_W
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     start_in,
  input  logic [bnn_pkg::PASS_W-1:0] cfg_passes_in,
  input  logic [ACC_W-1:0]         cfg_threshold_in,
  input  logic                     psum_valid_in,
  input  logic [PSUM_W-1:0]        psum_in,
  output logic                     psum_ready_out,
  input  logic                     flush_in,
  output logic                     act_valid_out,
  output logic [ACT_W-1:0]         act_data_out,
  input  logic                     act_ready_in
);
  import bnn_pkg::*;
  logic [PASS_W-1:0] passes_q, pass_cnt_q, pass_cnt_d;
  logic [ACC_W-1:0] thr_q, acc_q, acc_d;
  logic signed [ACC_W:0] sum, thr_ext;
  logic ready, has_bits, accept, last, bit_v, bit_val, flush_go;
  // one guard bit keeps the compare exact for any acc/psum combination
  assign sum = {acc_q[ACC_W-1], acc_q} + {{(ACC_W + 1 - PSUM_W){psum_in[PSUM_W-1]}}, psum_in};
  assign thr_ext = {thr_q[ACC_W-1], thr_q};
  always_comb begin
    accept = psum_valid_in && ready;
    last = pass_cnt_q == passes_q - PASS_W'(1);
    bit_v = accept && last;
    bit_val = sum >= thr_ext;
    flush_go = flush_in && ready && (bit_v || has_bits);
    acc_d = (bit_v || flush_go) ? '0 : accept ? sum[ACC_W-1:0] : acc_q;
    pass_cnt_d = (bit_v || flush_go) ? '0 : accept ? pass_cnt_q + PASS_W'(1) : pass_cnt_q;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      passes_q <= PASS_W'(1);
      thr_q <= '0;
      acc_q <= '0;
      pass_cnt_q <= '0;
    end else if (start_in) begin
      passes_q <= (cfg_passes_in == '0) ? PASS_W'(1) : cfg_passes_in;
      thr_q <= cfg_threshold_in;
      acc_q <= '0;
      pass_cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      pass_cnt_q <= pass_cnt_d;
    end
  end
  psum_bit_packer #(.N(ACT_W)) u_packer (
    .clk_i(clk_in),
    .rst_i(rst_in),
    .clr_i(start_in),
    .bit_valid_i(bit_v),
    .bit_i(bit_val),
    .flush_i(flush_go),
    .word_ready_i(act_ready_in),
    .ready_o(ready),
    .has_bits_o(has_bits),
    .word_valid_o(act_valid_out),
    .word_o(act_data_out)
  );
  assign psum_ready_out = ready;
endmodule

// File: tb/tb_psum_collector.sv
// tb_psum_collector: scoreboard bench with a neuron-level reference model
module tb_psum_collector;
  logic clk_in = 1'b0;
  logic rst_in, start_in, psum_valid_in, flush_in, act_ready_in;
  logic [3:0] cfg_passes_in;
  logic [10:0] cfg_threshold_in;
  logic [6:0] psum_in;
  logic psum_ready_out, act_valid_out;
  logic [8:0] act_data_out;
  int checks = 0, failures = 0;
  logic [8:0] exp_q[$];
  logic [8:0] exp_w;
  int m_acc, m_pc, m_passes, m_thr, m_nb;
  logic [8:0] m_word;
  bit m_emit;

  psum_collector dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
    .cfg_passes_in(cfg_passes_in), .cfg_threshold_in(cfg_threshold_in),
    .psum_valid_in(psum_valid_in), .psum_in(psum_in), .psum_ready_out(psum_ready_out),
    .flush_in(flush_in), .act_valid_out(act_valid_out), .act_data_out(act_data_out),
    .act_ready_in(act_ready_in)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
    end
  endtask

  // monitor: every handshaken word must match the oldest predicted word
  always @(negedge clk_in) begin
    if (!rst_in && act_valid_out && act_ready_in) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL word_unexpected got=%b", act_data_out);
      end else begin
        exp_w = exp_q.pop_front();
        if (act_data_out !== exp_w) begin
          failures++;
          $display("FAIL word_data got=%b want=%b at %0t", act_data_out, exp_w, $time);
        end
      end
    end
  end

  // one clock: drive inputs, advance the neuron-level model, check handshake outputs
  task automatic step(input bit st, input int cp, input int ct, input bit v, input int p,
                      input bit fl, input bit rdy);
    start_in = st;
    cfg_passes_in = cp[3:0];
    cfg_threshold_in = ct[10:0];
    psum_valid_in = v;
    psum_in = p[6:0];
    flush_in = fl;
    act_ready_in = st ? 1'b0 : rdy;
    if (st) begin
      m_acc = 0; m_pc = 0; m_nb = 0; m_word = '0; m_emit = 0;
      m_passes = (cp == 0) ? 1 : cp;
      m_thr = ct;
      exp_q.delete();
    end else if (m_emit) begin
      if (rdy) m_emit = 0;
    end else begin
      if (v) begin
        m_acc += p;
        m_pc++;
        if (m_pc == m_passes) begin
          m_word[m_nb] = (m_acc >= m_thr);
          m_nb++;
          m_acc = 0;
          m_pc = 0;
        end
      end
      if (m_nb == 9 || (fl && m_nb > 0)) begin
        exp_q.push_back(m_word);
        m_emit = 1; m_nb = 0; m_word = '0; m_acc = 0; m_pc = 0;
      end
    end
    @(posedge clk_in);
    #1;
    chk("psum_ready", int'(psum_ready_out), int'(!m_emit));
    chk("act_valid", int'(act_valid_out), int'(m_emit));
  endtask

  task automatic beat(input int p, input bit rdy);
    step(0, 0, 0, 1, p, 0, rdy);
  endtask

  task automatic idle(input int n, input bit fl, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, fl, rdy);
  endtask

  initial begin
    rst_in = 1; start_in = 0; cfg_passes_in = 0; cfg_threshold_in = 0;
    psum_valid_in = 0; psum_in = 0; flush_in = 0; act_ready_in = 0;
    m_acc = 0; m_pc = 0; m_passes = 1; m_thr = 0; m_nb = 0; m_word = '0; m_emit = 0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_ready", int'(psum_ready_out), 1);
    chk("rst_valid", int'(act_valid_out), 0);
    chk("rst_data", int'(act_data_out), 0);
    rst_in = 0;
    // default config after reset: passes=1, thr=0
    for (int i = 0; i < 9; i++) beat((i % 2 == 0) ? 1 : -1, 1);
    idle(2, 0, 1);
    // alternating +/-1 word
    step(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) beat((i % 2 == 0) ? 1 : -1, 1);
    chk("word_1cyc_valid", int'(act_valid_out), 1);
    chk("word_1cyc_data", int'(act_data_out), 9'b101010101);
    idle(1, 0, 1);
    // three passes around threshold 5, then a held word with beats offered
    step(1, 3, 5, 0, 0, 0, 0);
    for (int n = 0; n < 9; n++) begin
      beat(2, 0); beat(2, 0); beat((n % 2 == 0) ? 1 : 0, 0);
    end
    for (int i = 0; i < 4; i++) beat(7, 0);
    chk("held_data", int'(act_data_out), 9'b101010101);
    idle(1, 0, 1);
    // flush of a partial word, then flush with nothing written
    step(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) beat(63, 1);
    idle(1, 1, 0);
    chk("flush_data", int'(act_data_out), 9'b000000111);
    idle(1, 0, 1);
    idle(3, 1, 1);
    // flush coincident with a completing beat
    step(0, 0, 0, 1, 4, 1, 1);
    idle(2, 0, 1);
    // start mid-word and during EMIT
    step(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) beat(3, 1);
    step(1, 2, -3, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++) beat((i % 4 < 2) ? -1 : -2, 0);
    idle(2, 0, 0);
    step(1, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 9; i++) beat(-5 + i, 1);
    idle(2, 0, 1);
    // accumulator extremes around threshold 945
    step(1, 15, 945, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) beat(63, 1);
    idle(1, 1, 1);
    idle(2, 0, 1);
    step(1, 15, 946, 0, 0, 0, 0);
    for (int i = 0; i < 15; i++) beat(63, 1);
    idle(1, 1, 1);
    idle(2, 0, 1);
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) beat((i % 3 == 0) ? -1 : 0, 1);
    idle(2, 0, 1);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0)
        step(1, $urandom_range(0, 4), int'($urandom_range(0, 60)) - 30, 0, 0, 0, 0);
      else
        step(0, 0, 0, $urandom_range(0, 9) < 7, int'($urandom_range(0, 126)) - 63,
             $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6);
    end
    idle(4, 0, 1);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
